axi_slave_responder: RTL
========================

# axi_slave_responder

AXI slave-end responder with a word-addressed memory that answers one crossbar slave port: AW/W/B on the write side, AR/R on the read side. It sits behind `S_*[n]` of the crossbar in RTL simulation and the UVM bench, one instance per slave index. The protocol checkers observe real handshakes and data round-trips instead of ideal slave stubs.

## Interface

**Parameters**

- `WIDTH`, 32: data and address width in bits.
- `SIZE`, 3: `AxSIZE` width. `AxBURST` and `xRESP` are `SIZE-1` bits wide.
- `ID_W`, `WIDTH/4`: slave-side ID width.
- `DEPTH`, 256: memory depth in `WIDTH`-bit words. Must be a power of 2.
- `BASE`, 0: byte address of word 0.

**Ports**

- `clk`, in, 1: clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `S_AWVALID`/`S_AWREADY`, in/out, 1 each: write address handshake.
- `S_AWID`, `S_AWADDR`, `S_AWLEN`, `S_AWSIZE`, `S_AWBURST`, in, `ID_W`/`WIDTH`/8/`SIZE`/`SIZE-1`: write address fields.
- `S_WVALID`/`S_WREADY`, in/out, 1 each: write data handshake.
- `S_WDATA`, `S_WSTRB`, `S_WLAST`, `S_WID`, in, `WIDTH`/`WIDTH/8`/1/`ID_W`: write data fields.
- `S_BVALID`/`S_BREADY`, out/in, 1 each: write response handshake.
- `S_BID`, `S_BRESP`, out, `ID_W`/`SIZE-1`: write response fields.
- `S_ARVALID`/`S_ARREADY`, in/out, 1 each: read address handshake.
- `S_ARID`, `S_ARADDR`, `S_ARLEN`, `S_ARSIZE`, `S_ARBURST`, in: read address fields, same widths as AW.
- `S_RVALID`/`S_RREADY`, out/in, 1 each: read data handshake.
- `S_RID`, `S_RDATA`, `S_RRESP`, `S_RLAST`, out, `ID_W`/`WIDTH`/`SIZE-1`/1: read data fields.

## Operation

**Write FSM: `W_IDLE` → `W_DATA` → `W_RESP` → `W_IDLE`**

- `W_IDLE`: `S_AWREADY=1`. On the AW handshake, latch ID, address, LEN, SIZE and BURST; clear the beat counter; go to `W_DATA`.
- `W_DATA`: `S_WREADY=1`. Each W handshake:
  - writes byte lane *i* of `mem[addr]` where `S_WSTRB[i]=1`;
  - advances the address and the beat counter.
- On the beat where `count==LEN`, go to `W_RESP`. The beat counter alone determines the burst end; `S_WLAST` and `S_WID` are not used.
- `W_RESP`: `S_BVALID=1`, `S_BID` = latched ID, `S_BRESP=OKAY`. On `S_BREADY`, go to `W_IDLE`.

**Read FSM: `R_IDLE` → `R_DATA` → `R_IDLE`**

- `R_IDLE`: `S_ARREADY=1`. On the AR handshake, latch the fields and go to `R_DATA`.
- `R_DATA`: `S_RVALID=1`, `S_RDATA = mem[addr]` (asynchronous array read), `S_RID` = latched ID, `S_RLAST = (count==LEN)`.
  - Each R handshake advances the address.
  - The beat with `S_RLAST=1` returns the FSM to `R_IDLE`.

**Address rules** (shared by both paths)

- Word index = `(addr-BASE)[log2(WIDTH/8)+log2(DEPTH)-1 : log2(WIDTH/8)]`.
- Increment per beat = `1<<AxSIZE`.
- FIXED (`00`): address unchanged.
- INCR (`01`): `addr += incr`.
- WRAP (`10`): wrap boundary = `(LEN+1)<<SIZE`. The address wraps to the aligned boundary base. LEN must be 1, 3, 7 or 15; any other LEN is treated as INCR.
- Reserved burst type (`11`) is treated as INCR.

**Concurrency**

- The read and write paths are fully independent and may be active in the same cycle.
- A same-address read and write in one cycle: R returns the old data, and the write takes effect the next cycle.

## Timing

- Reset (asynchronous): both FSMs go to IDLE.
  - `S_AWREADY=1`, `S_ARREADY=1`.
  - `S_WREADY`, `S_BVALID`, `S_RVALID`, `S_RLAST` = 0.
  - `S_BID`, `S_BRESP`, `S_RID`, `S_RRESP` = 0.
  - Memory contents are cleared to 0.
- Reset asserted mid-burst aborts the burst. No B or R is issued afterwards for the aborted burst.
- AW handshake in cycle N → `S_WREADY=1` from cycle N+1.
- Last W beat in cycle M → `S_BVALID=1` in cycle M+1.
- AR handshake in cycle N → first `S_RVALID` in cycle N+1.
- `S_RVALID` stays high with stable payload until `S_RREADY`.
- Each path carries one outstanding transaction. A new AW/AR is accepted only in IDLE, so back-to-back bursts have one idle cycle between them.

## Configuration

Macro `AXI_SLV_ERR_EN`:

- **Defined:** a burst whose start address lies outside `[BASE, BASE+DEPTH*WIDTH/8)`:
  - returns `SLVERR` (`2'b10`) on B, or on every R beat;
  - performs no memory writes;
  - returns `S_RDATA=0`.
- **Undefined:** addresses alias modulo `DEPTH` and always return `OKAY`.

## Structure

- **Package `axi_pkg`:**
  - `burst_t` enum (`FIXED`, `INCR`, `WRAP`);
  - `resp_t` enum (`OKAY`, `EXOKAY`, `SLVERR`, `DECERR`);
  - `wstate_t` and `rstate_t` enums.
- **Sub-module `axi_burst_addr`:** combinational next-address calculator (`addr`, `len`, `size`, `burst` → `next_addr`). It is instantiated twice, once per path.

## Test plan

- **Single INCR write then read:** AW addr `0x10`, len 0, size 2, W `0xDEADBEEF`, strb `0xF`, followed by AR to the same address.
  → B `OKAY` with `BID` echoed; R `0xDEADBEEF` with `RLAST=1`.
- **INCR len 3 from `0x20`:** data 1, 2, 3, 4 with `S_BREADY` held low for 3 cycles.
  → `S_BVALID` holds; a read-back returns 1, 2, 3, 4 with `RLAST` on beat 4 only.
- **WRAP len 3, size 2, start `0x38`:**
  → beat addresses `0x38`, `0x3C`, `0x30`, `0x34`, confirmed by read-back.
- **Strobe `0x5` over `0xFFFFFFFF`:** write data `0x11223344`.
  → a read returns `0xFF22FF44`.
- **Random `S_RREADY` stalls plus concurrent write bursts on a disjoint address range:**
  → data stable while stalled; no cross-path corruption.
- **Reset mid-W-burst after 2 of 4 beats:**
  → all outputs return to their reset values; the next AW is accepted immediately.
  → With `AXI_SLV_ERR_EN` defined, a write to `BASE+0x400` with the default parameters returns `SLVERR`.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI types for the slave responder: burst/response encodings,
// FSM state enums and the WRAP length qualifier.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Reserved burst type and illegal WRAP lengths advance as INCR.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3
) (
    input  logic [WIDTH-1:0] addr,
    input  logic [7:0]       len,
    input  logic [SIZE-1:0]  size,
    input  logic [SIZE-2:0]  burst,
    output logic [WIDTH-1:0] next_addr
);

    logic [WIDTH-1:0] incr;
    logic [WIDTH-1:0] span;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] sum;
    logic [1:0]       btype;

    // Select the next address according to the burst type
    always_comb begin
        incr  = WIDTH'(1) << size;
        span  = (WIDTH'(len) + WIDTH'(1)) << size;
        mask  = span - WIDTH'(1);
        sum   = addr + incr;
        btype = 2'(burst);
        next_addr = sum;
        case (btype)
            FIXED:   next_addr = addr;
            WRAP:    if (wrap_len_ok(len)) next_addr = (addr & ~mask) | (sum & mask);
            default: next_addr = sum;
        endcase
    end

endmodule

// File: rtl/axi_slave_responder.sv
// AXI slave responder backed by a word-addressed memory.
// Independent write (AW/W/B) and read (AR/R) FSMs, one outstanding burst each.
// Optional macro AXI_SLV_ERR_EN: out-of-range start address answers SLVERR,
// suppresses writes and returns zero read data.
module axi_slave_responder
    import axi_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3,
    parameter int ID_W  = WIDTH / 4,
    parameter int DEPTH = 256,
    parameter int BASE  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               S_AWVALID,
    output logic               S_AWREADY,
    input  logic [ID_W-1:0]    S_AWID,
    input  logic [WIDTH-1:0]   S_AWADDR,
    input  logic [7:0]         S_AWLEN,
    input  logic [SIZE-1:0]    S_AWSIZE,
    input  logic [SIZE-2:0]    S_AWBURST,
    input  logic               S_WVALID,
    output logic               S_WREADY,
    input  logic [WIDTH-1:0]   S_WDATA,
    input  logic [WIDTH/8-1:0] S_WSTRB,
    input  logic               S_WLAST,
    input  logic [ID_W-1:0]    S_WID,
    output logic               S_BVALID,
    input  logic               S_BREADY,
    output logic [ID_W-1:0]    S_BID,
    output logic [SIZE-2:0]    S_BRESP,
    input  logic               S_ARVALID,
    output logic               S_ARREADY,
    input  logic [ID_W-1:0]    S_ARID,
    input  logic [WIDTH-1:0]   S_ARADDR,
    input  logic [7:0]         S_ARLEN,
    input  logic [SIZE-1:0]    S_ARSIZE,
    input  logic [SIZE-2:0]    S_ARBURST,
    output logic               S_RVALID,
    input  logic               S_RREADY,
    output logic [ID_W-1:0]    S_RID,
    output logic [WIDTH-1:0]   S_RDATA,
    output logic [SIZE-2:0]    S_RRESP,
    output logic               S_RLAST
);

    localparam int STRB = WIDTH / 8;
    localparam int LSB  = $clog2(STRB);
    localparam int DW   = $clog2(DEPTH);
    localparam logic [SIZE-2:0] RESP_OK  = (SIZE-1)'(OKAY);
    localparam logic [SIZE-2:0] RESP_SLV = (SIZE-1)'(SLVERR);

    logic [WIDTH-1:0] mem [DEPTH];

    wstate_t          wstate;
    logic [ID_W-1:0]  wid;
    logic [WIDTH-1:0] waddr, wnext, woff;
    logic [7:0]       wlen, wcnt;
    logic [SIZE-1:0]  wsize;
    logic [SIZE-2:0]  wburst;
    logic             werr;

    rstate_t          rstate;
    logic [WIDTH-1:0] raddr, rnext, roff;
    logic [7:0]       rlen, rcnt;
    logic [SIZE-1:0]  rsize;
    logic [SIZE-2:0]  rburst;
    logic             rerr;

    logic [DW-1:0]    wword, rword;
    logic             aw_err, ar_err;
    logic             unused_sigs;

    assign woff  = waddr - WIDTH'(BASE);
    assign roff  = raddr - WIDTH'(BASE);
    assign wword = woff[LSB+DW-1:LSB];
    assign rword = roff[LSB+DW-1:LSB];

`ifdef AXI_SLV_ERR_EN
    function automatic logic in_range(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] off;
        off = a - WIDTH'(BASE);
        return (a >= WIDTH'(BASE)) && ((off >> (LSB + DW)) == '0);
    endfunction
    assign aw_err = !in_range(S_AWADDR);
    assign ar_err = !in_range(S_ARADDR);
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    // Burst end is decided by the beat counter, so WLAST/WID are ignored
    assign unused_sigs = ^{S_WLAST, S_WID, woff[LSB-1:0], woff[WIDTH-1:LSB+DW],
                           roff[LSB-1:0], roff[WIDTH-1:LSB+DW]};

    axi_burst_addr #(.WIDTH(WIDTH), .SIZE(SIZE)) u_waddr (
        .addr(waddr), .len(wlen), .size(wsize), .burst(wburst), .next_addr(wnext)
    );

    axi_burst_addr #(.WIDTH(WIDTH), .SIZE(SIZE)) u_raddr (
        .addr(raddr), .len(rlen), .size(rsize), .burst(rburst), .next_addr(rnext)
    );

    // Asynchronous array read: a same-cycle write to this word shows up next cycle
    assign S_RDATA = rerr ? '0 : mem[rword];

    // Write FSM: accept AW, store strobed beats, answer on B; owns the memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate    <= W_IDLE;
            S_AWREADY <= 1'b1;
            S_WREADY  <= 1'b0;
            S_BVALID  <= 1'b0;
            S_BID     <= '0;
            S_BRESP   <= '0;
            wid       <= '0;
            waddr     <= '0;
            wlen      <= '0;
            wcnt      <= '0;
            wsize     <= '0;
            wburst    <= '0;
            werr      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (S_AWVALID && S_AWREADY) begin
                        wid       <= S_AWID;
                        waddr     <= S_AWADDR;
                        wlen      <= S_AWLEN;
                        wsize     <= S_AWSIZE;
                        wburst    <= S_AWBURST;
                        wcnt      <= '0;
                        werr      <= aw_err;
                        S_AWREADY <= 1'b0;
                        S_WREADY  <= 1'b1;
                        wstate    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (S_WVALID && S_WREADY) begin
                        if (!werr) begin
                            for (int unsigned i = 0; i < STRB; i++)
                                if (S_WSTRB[i]) mem[wword][8*i +: 8] <= S_WDATA[8*i +: 8];
                        end
                        waddr <= wnext;
                        wcnt  <= wcnt + 8'd1;
                        if (wcnt == wlen) begin
                            S_WREADY <= 1'b0;
                            S_BVALID <= 1'b1;
                            S_BID    <= wid;
                            S_BRESP  <= werr ? RESP_SLV : RESP_OK;
                            wstate   <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_BREADY) begin
                        S_BVALID  <= 1'b0;
                        S_AWREADY <= 1'b1;
                        wstate    <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: accept AR, then present beats until the RLAST handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate    <= R_IDLE;
            S_ARREADY <= 1'b1;
            S_RVALID  <= 1'b0;
            S_RLAST   <= 1'b0;
            S_RID     <= '0;
            S_RRESP   <= '0;
            raddr     <= '0;
            rlen      <= '0;
            rcnt      <= '0;
            rsize     <= '0;
            rburst    <= '0;
            rerr      <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (S_ARVALID && S_ARREADY) begin
                        raddr     <= S_ARADDR;
                        rlen      <= S_ARLEN;
                        rsize     <= S_ARSIZE;
                        rburst    <= S_ARBURST;
                        rcnt      <= '0;
                        rerr      <= ar_err;
                        S_RID     <= S_ARID;
                        S_RRESP   <= ar_err ? RESP_SLV : RESP_OK;
                        S_RLAST   <= (S_ARLEN == 8'd0);
                        S_RVALID  <= 1'b1;
                        S_ARREADY <= 1'b0;
                        rstate    <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_RREADY) begin
                        if (S_RLAST) begin
                            S_RVALID  <= 1'b0;
                            S_RLAST   <= 1'b0;
                            S_ARREADY <= 1'b1;
                            rstate    <= R_IDLE;
                        end else begin
                            raddr   <= rnext;
                            rcnt    <= rcnt + 8'd1;
                            S_RLAST <= ((rcnt + 8'd1) == rlen);
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule
